// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode stage: width defaults, instruction
// field positions, opcode values, register-reference bit indices and the
// sequencer state encoding.
package fetch_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Opcode values carried in IR[6:4]
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_RR  = 3'd7;

    // Instruction bit positions
    localparam int IND_BIT = 7;
    localparam int OPC_HI  = 6;
    localparam int OPC_LO  = 4;

    // Register-reference micro-op bits within IR[3:0]
    localparam int RR_CLA = 3;
    localparam int RR_CMA = 2;
    localparam int RR_CIR = 1;
    localparam int RR_CIL = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_INDIRECT = 3'd3,
        ST_ISSUE    = 3'd4
    } state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational split of an instruction word into its fields.
// The direct address and the register-reference bits are mutually
// exclusive: whichever one does not apply is forced to zero.
module instr_field_decode
    import fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic              ind,
    output logic              is_rr,
    output logic [3:0]        rr,
    output logic [ADDR_W-1:0] ea
);

    // Field extraction; rr and ea are gated by the register-reference flag
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        opcode = ir[OPC_HI:OPC_LO];
        ind    = ir[IND_BIT];
        is_rr  = (ir[OPC_HI:OPC_LO] == OP_RR);
        rr     = '0;
        ea     = '0;
        if (is_rr) begin
            rr = {ir[RR_CLA], ir[RR_CMA], ir[RR_CIR], ir[RR_CIL]};
        end else begin
            ea = ir[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch/decode stage. Owns the PC and IR, reads one instruction
// per pass from the program RAM, optionally resolves an indirect address with
// a second read, and offers the decoded instruction to execute over a
// valid/ready handshake. A redirect reloads the PC and drops whatever is in
// flight unless it coincides with the issue handshake.
//
// Build option: define FETCH_INDIRECT_EN to include the INDIRECT state.
// Without it, IR[7] is still reported on issue_ind but the effective address
// is always IR[3:0] and there is no second RAM read.
module fetch_decode_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [2:0]        issue_opcode,
    output logic              issue_ind,
    output logic              issue_is_rr,
    output logic [3:0]        issue_rr,
    output logic [ADDR_W-1:0] issue_ea,
    output logic [ADDR_W-1:0] issue_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] fetch_pc;

    logic [2:0]        dec_opcode;
    logic              dec_ind;
    logic              dec_is_rr;
    logic [3:0]        dec_rr;
    logic [ADDR_W-1:0] dec_ea;
    logic              go_indirect;
    logic              handshake;

    instr_field_decode #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .ir     (ir),
        .opcode (dec_opcode),
        .ind    (dec_ind),
        .is_rr  (dec_is_rr),
        .rr     (dec_rr),
        .ea     (dec_ea)
    );

`ifdef FETCH_INDIRECT_EN
    assign go_indirect = dec_ind && !dec_is_rr;
`else
    assign go_indirect = 1'b0;
`endif

    assign handshake = (state == ST_ISSUE) && issue_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect restarts fetching from any state
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = en ? ST_FETCH : ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:     if (en) state_nxt = ST_FETCH;
                ST_FETCH:    state_nxt = ST_DECODE;
                ST_DECODE:   state_nxt = go_indirect ? ST_INDIRECT : ST_ISSUE;
`ifdef FETCH_INDIRECT_EN
                ST_INDIRECT: state_nxt = ST_ISSUE;
`endif
                ST_ISSUE:    if (handshake) state_nxt = en ? ST_FETCH : ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Memory port and issue strobe, decoded from state alone
    always_comb begin
        mem_read    = 1'b0;
        mem_addr    = '0;
        issue_valid = 1'b0;
        unique case (state)
            ST_FETCH: begin
                mem_read = 1'b1;
                mem_addr = pc;
            end
`ifdef FETCH_INDIRECT_EN
            ST_INDIRECT: begin
                mem_read = 1'b1;
                mem_addr = ir[ADDR_W-1:0];
            end
`endif
            ST_ISSUE: issue_valid = 1'b1;
            default: ;
        endcase
    end

    // PC / IR / EA datapath; a redirect overrides the PC increment and
    // suppresses capture for the instruction being discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ea       <= '0;
            fetch_pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    ir       <= mem_data;
                    fetch_pc <= pc;
                    pc       <= pc + 1'b1;
                end
                ST_DECODE: begin
                    if (!go_indirect) ea <= dec_ea;
                end
`ifdef FETCH_INDIRECT_EN
                ST_INDIRECT: ea <= mem_data[ADDR_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Issue fields come straight from the held IR/EA, stable throughout ISSUE
    assign issue_opcode = dec_opcode;
    assign issue_ind    = dec_ind;
    assign issue_is_rr  = dec_is_rr;
    assign issue_rr     = dec_rr;
    assign issue_ea     = ea;
    assign issue_pc     = fetch_pc;

endmodule
